control_seq: RTL and testbench

- Parametrised multi-cycle control sequencer for the nic8-class CPU.
- Latches the instruction register itself in a FETCH state and decodes it in an EXEC state into active-low one-hot load/assert strobes.
- Evaluates conditional jumps on the zero and carry flags.
- Stalls on a memory-ready handshake and supports a HALT encoding.
- Replaces the single-cycle combinational decoder plus clock-gated triggers with synchronous one-cycle enables.

---
 rtl/control_seq_pkg.sv | 42 ++++
 rtl/control_seq_if.sv | 73 +++++++
 rtl/control_seq_decoder.sv | 15 +
 rtl/control_seq.sv | 119 +++++++++++
 tb/tb_control_seq.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/control_seq_pkg.sv
// Shared types and constants for the control_seq sequencer.
// IR layout, MSB first: {carry-in bit, dest, subtract bit, source}.
package control_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_e;

  localparam int DEST_PC  = 1;
  localparam int DEST_MEM = 5;
  localparam int SRC_ROM  = 0;
  localparam int SRC_RAM  = 5;

  function automatic int ir_width(
    input int db,
    input int sb
  );
    return db + sb + 2;
  endfunction

  function automatic int src_lsb();
    return 0;
  endfunction

  function automatic int sub_pos(input int sb);
    return sb;
  endfunction

  function automatic int dest_lsb(input int sb);
    return sb + 1;
  endfunction

  function automatic int cin_pos(
    input int db,
    input int sb
  );
    return db + sb + 1;
  endfunction

endpackage

// File: rtl/control_seq_if.sv
// Bus/handshake bundle between the sequencer and the nic8 datapath.
// stepGo only exists when CONTROL_SINGLE_STEP_EN is defined.
interface control_seq_if
  import control_pkg::*;
#(
  parameter int DEST_BITS = 3,
  parameter int SRC_BITS  = 3
);

  localparam int IR_W = ir_width(DEST_BITS, SRC_BITS);
  localparam int NL   = 2 ** DEST_BITS;
  localparam int NA   = 2 ** SRC_BITS;

  logic [IR_W-1:0] irData;
  logic            aIsZero;
  logic            flagCarry;
  logic            memReady;
`ifdef CONTROL_SINGLE_STEP_EN
  logic            stepGo;
`endif

  logic [IR_W-1:0] ir;
  logic            fetch;
  logic            pcIncr;
  logic [NL-1:0]   loadBar;
  logic [NA-1:0]   assertBar;
  logic            memReq;
  logic            doSubtract;
  logic            doCarryIn;
  logic            doJumpBar;
  logic            halted;

  modport master (
`ifdef CONTROL_SINGLE_STEP_EN
    input  stepGo,
`endif
    input  irData,
    input  aIsZero,
    input  flagCarry,
    input  memReady,
    output ir,
    output fetch,
    output pcIncr,
    output loadBar,
    output assertBar,
    output memReq,
    output doSubtract,
    output doCarryIn,
    output doJumpBar,
    output halted
  );

  modport slave (
`ifdef CONTROL_SINGLE_STEP_EN
    output stepGo,
`endif
    output irData,
    output aIsZero,
    output flagCarry,
    output memReady,
    input  ir,
    input  fetch,
    input  pcIncr,
    input  loadBar,
    input  assertBar,
    input  memReq,
    input  doSubtract,
    input  doCarryIn,
    input  doJumpBar,
    input  halted
  );

endinterface

// File: rtl/control_seq_decoder.sv
// N-to-2**N one-hot decoder with active-low outputs and enable.
module onehot_low_decoder #(
  parameter int N = 3
) (
  input  logic [N-1:0]      sel_i,
  input  logic              en_i,
  output logic [2**N-1:0]   out_o
);

  always_comb begin
    out_o = '1;
    if (en_i) out_o[sel_i] = 1'b0;
  end

endmodule

// File: rtl/control_seq.sv
// nic8 multi-cycle control sequencer: FETCH / EXEC / HALT.
// Optional CONTROL_SINGLE_STEP_EN adds stepGo to gate FETCH.
module control_seq
  import control_pkg::*;
#(
  parameter int DEST_BITS = 3,
  parameter int SRC_BITS  = 3
) (
  input  logic          clk,
  input  logic          reset,
  control_seq_if.master bus
);

  localparam int IR_W = ir_width(DEST_BITS, SRC_BITS);
  localparam int D_LO = dest_lsb(SRC_BITS);
  localparam int S_LO = src_lsb();
  localparam int B3   = sub_pos(SRC_BITS);
  localparam int B7   = cin_pos(DEST_BITS, SRC_BITS);

  localparam logic [DEST_BITS-1:0] D_PC  = DEST_BITS'(DEST_PC);
  localparam logic [DEST_BITS-1:0] D_MEM = DEST_BITS'(DEST_MEM);
  localparam logic [SRC_BITS-1:0]  S_ROM = SRC_BITS'(SRC_ROM);
  localparam logic [SRC_BITS-1:0]  S_RAM = SRC_BITS'(SRC_RAM);

  state_e          state_q, state_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic            fetch_q;
  logic            halted_q;

  logic [DEST_BITS-1:0] dest;
  logic [SRC_BITS-1:0]  src;
  logic                 b3;
  logic                 b7;
  logic                 go;
  logic                 in_exec;
  logic                 mem_acc;
  logic                 complete;
  logic                 is_jump;
  logic                 take;
  logic                 is_halt;
  logic                 ld_en;

  assign dest = ir_q[D_LO +: DEST_BITS];
  assign src  = ir_q[S_LO +: SRC_BITS];
  assign b3   = ir_q[B3];
  assign b7   = ir_q[B7];

`ifdef CONTROL_SINGLE_STEP_EN
  assign go = bus.stepGo;
`else
  assign go = 1'b1;
`endif

  assign in_exec  = (state_q == EXEC);
  assign mem_acc  = (src == S_RAM) | (dest == D_MEM);
  // Memory instructions complete on the first cycle with memReady high.
  assign complete = in_exec & (~mem_acc | bus.memReady);
  assign is_jump  = (dest == D_PC);
  assign take     = (~b3 | bus.aIsZero) & (~b7 | bus.flagCarry);
  assign is_halt  = (&dest) & (&src);
  assign ld_en    = complete & (~is_jump | take);

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      FETCH: begin
        if (go) begin
          state_d = EXEC;
          ir_d    = bus.irData;
        end
      end
      EXEC: begin
        if (complete) state_d = is_halt ? HALT : FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FETCH;
      ir_q     <= '0;
      fetch_q  <= 1'b1;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      fetch_q  <= (state_d == FETCH);
      halted_q <= (state_d == HALT);
    end
  end

  onehot_low_decoder #(.N(DEST_BITS)) u_ld_dec (
    .sel_i (dest),
    .en_i  (ld_en),
    .out_o (bus.loadBar)
  );

  onehot_low_decoder #(.N(SRC_BITS)) u_as_dec (
    .sel_i (src),
    .en_i  (in_exec),
    .out_o (bus.assertBar)
  );

  // pcIncr is forced low while reset is held, not just after the edge.
  assign bus.pcIncr = ~reset &
                      ((fetch_q & go) | (complete & (src == S_ROM)));

  assign bus.ir         = ir_q;
  assign bus.fetch      = fetch_q;
  assign bus.halted     = halted_q;
  assign bus.memReq     = in_exec & mem_acc;
  assign bus.doJumpBar  = ~(complete & is_jump & take);
  assign bus.doSubtract = b3;
  assign bus.doCarryIn  = b7;

endmodule

// File: tb/tb_control_seq.sv
// Scoreboard bench for control_seq (DEST_BITS = SRC_BITS = 3).
// Single-step scenario runs only when CONTROL_SINGLE_STEP_EN is defined.
module tb_control_seq;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  control_seq_if #(.DEST_BITS(3), .SRC_BITS(3)) bus ();

  control_seq #(.DEST_BITS(3), .SRC_BITS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct {
    logic       f;
    logic       pc;
    logic [7:0] ld;
    logic [7:0] as;
    logic       mr;
    logic       jb;
    logic       h;
    logic [7:0] ir;
  } exp_t;

  exp_t  sb[$];
  string tq[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ef(input logic [7:0] v, input logic pc);
    exp_t e;
    e.f = 1'b1; e.pc = pc; e.ld = 8'hFF; e.as = 8'hFF;
    e.mr = 1'b0; e.jb = 1'b1; e.h = 1'b0; e.ir = v;
    return e;
  endfunction

  function automatic exp_t ee(input logic [7:0] v, input logic [7:0] ld,
                              input logic [7:0] as, input logic pc,
                              input logic mr, input logic jb);
    exp_t e;
    e.f = 1'b0; e.pc = pc; e.ld = ld; e.as = as;
    e.mr = mr; e.jb = jb; e.h = 1'b0; e.ir = v;
    return e;
  endfunction

  function automatic exp_t eh(input logic [7:0] v);
    exp_t e;
    e.f = 1'b0; e.pc = 1'b0; e.ld = 8'hFF; e.as = 8'hFF;
    e.mr = 1'b0; e.jb = 1'b1; e.h = 1'b1; e.ir = v;
    return e;
  endfunction

  task automatic cmp_all(input string t, input exp_t e);
    chk({t, ".fetch"},  16'(bus.fetch),      16'(e.f));
    chk({t, ".pcIncr"}, 16'(bus.pcIncr),     16'(e.pc));
    chk({t, ".ldBar"},  16'(bus.loadBar),    16'(e.ld));
    chk({t, ".asBar"},  16'(bus.assertBar),  16'(e.as));
    chk({t, ".memReq"}, 16'(bus.memReq),     16'(e.mr));
    chk({t, ".jmpBar"}, 16'(bus.doJumpBar),  16'(e.jb));
    chk({t, ".halted"}, 16'(bus.halted),     16'(e.h));
    chk({t, ".ir"},     16'(bus.ir),         16'(e.ir));
    chk({t, ".sub"},    16'(bus.doSubtract), 16'(e.ir[3]));
    chk({t, ".cin"},    16'(bus.doCarryIn),  16'(e.ir[7]));
  endtask

  always @(negedge clk) begin : mon
    exp_t  e;
    string t;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      t = tq.pop_front();
      cmp_all(t, e);
    end
  end

  task automatic step(input string t, input exp_t e);
    sb.push_back(e);
    tq.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset(input string t);
    #1;
    reset = 1'b1;
    #1;
    cmp_all(t, ef(8'h00, 1'b0));
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bus.irData    = 8'h00;
    bus.aIsZero   = 1'b0;
    bus.flagCarry = 1'b0;
    bus.memReady  = 1'b1;
`ifdef CONTROL_SINGLE_STEP_EN
    bus.stepGo    = 1'b1;
`endif
    @(posedge clk);
    #1;
    step("rst", ef(8'h00, 1'b0));
    reset = 1'b0;

    bus.irData = 8'h20;
    step("s1.fetch", ef(8'h00, 1'b1));
    step("s1.exec", ee(8'h20, 8'hFB, 8'hFE, 1'b1, 1'b0, 1'b1));
    bus.irData = 8'h18;
    step("s1.refetch", ef(8'h20, 1'b1));

    step("s2.nz", ee(8'h18, 8'hFF, 8'hFE, 1'b1, 1'b0, 1'b1));
    bus.aIsZero = 1'b1;
    step("s2.f1", ef(8'h18, 1'b1));
    step("s2.z", ee(8'h18, 8'hFD, 8'hFE, 1'b1, 1'b0, 1'b0));
    bus.irData    = 8'h98;
    bus.flagCarry = 1'b0;
    step("s2.f2", ef(8'h18, 1'b1));
    step("s2.nc", ee(8'h98, 8'hFF, 8'hFE, 1'b1, 1'b0, 1'b1));
    bus.flagCarry = 1'b1;
    step("s2.f3", ef(8'h98, 1'b1));
    step("s2.c", ee(8'h98, 8'hFD, 8'hFE, 1'b1, 1'b0, 1'b0));

    bus.aIsZero  = 1'b0;
    bus.irData   = 8'h25;
    bus.memReady = 1'b0;
    step("s3.f", ef(8'h98, 1'b1));
    for (int i = 0; i < 3; i++)
      step("s3.stall", ee(8'h25, 8'hFF, 8'hDF, 1'b0, 1'b1, 1'b1));
    bus.memReady = 1'b1;
    step("s3.done", ee(8'h25, 8'hFB, 8'hDF, 1'b0, 1'b1, 1'b1));
    bus.irData   = 8'h50;
    bus.memReady = 1'b0;
    step("s3.fetch", ef(8'h25, 1'b1));
    step("s3.stwait", ee(8'h50, 8'hFF, 8'hFE, 1'b0, 1'b1, 1'b1));
    bus.memReady = 1'b1;
    step("s3.stdone", ee(8'h50, 8'hDF, 8'hFE, 1'b1, 1'b1, 1'b1));

    bus.irData   = 8'h25;
    bus.memReady = 1'b0;
    step("s5.f", ef(8'h50, 1'b1));
    step("s5.stall", ee(8'h25, 8'hFF, 8'hDF, 1'b0, 1'b1, 1'b1));
    async_reset("s5.async");
    bus.memReady = 1'b1;

    bus.irData = 8'h77;
    step("s4.fetch", ef(8'h00, 1'b1));
    step("s4.exec", ee(8'h77, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < 20; i++) begin
      bus.irData    = 8'($urandom);
      bus.memReady  = 1'($urandom);
      bus.aIsZero   = 1'($urandom);
      bus.flagCarry = 1'($urandom);
      step("s4.halt", eh(8'h77));
    end
    async_reset("s4.reset");
    bus.irData    = 8'h20;
    bus.memReady  = 1'b1;
    bus.aIsZero   = 1'b0;
    bus.flagCarry = 1'b0;
    step("s4.after", ef(8'h00, 1'b1));
    step("s4.exec2", ee(8'h20, 8'hFB, 8'hFE, 1'b1, 1'b0, 1'b1));

`ifdef CONTROL_SINGLE_STEP_EN
    bus.irData = 8'h30;
    bus.stepGo = 1'b0;
    for (int i = 0; i < 5; i++)
      step("s6.hold", ef(8'h20, 1'b0));
    bus.stepGo = 1'b1;
    step("s6.go", ef(8'h20, 1'b1));
    bus.stepGo = 1'b0;
    step("s6.exec", ee(8'h30, 8'hF7, 8'hFE, 1'b1, 1'b0, 1'b1));
    for (int i = 0; i < 3; i++)
      step("s6.held", ef(8'h30, 1'b0));
`endif

    @(negedge clk);
    #1;
    chk("sb.drain", 16'(sb.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
